// File: rtl/cpu_bus_arbiter_if.sv
// Bus bundle between the CPU instruction/data masters, the arbiter and the
// system bus. Signal names keep their direction prefix as seen by the arbiter.
interface cpu_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 30
);
    logic [ADDR_WIDTH-1:0] i_IBus_Address;
    logic                  i_IBus_Read;
    logic [31:0]           o_IBus_ReadData;
    logic                  o_IBus_WaitReq;

    logic [ADDR_WIDTH-1:0] i_DBus_Address;
    logic [3:0]            i_DBus_ByteEn;
    logic                  i_DBus_Read;
    logic                  i_DBus_Write;
    logic [31:0]           i_DBus_WriteData;
    logic [31:0]           o_DBus_ReadData;
    logic                  o_DBus_WaitRequest;

    logic [ADDR_WIDTH-1:0] o_SBus_Address;
    logic [3:0]            o_SBus_ByteEn;
    logic                  o_SBus_Read;
    logic                  o_SBus_Write;
    logic [31:0]           o_SBus_WriteData;
    logic [31:0]           i_SBus_ReadData;
    logic                  i_SBus_WaitReq;

    logic [1:0]            o_Grant;

    // Arbiter view: it is the slave of both CPU buses.
    modport slave (
        input  i_IBus_Address, i_IBus_Read,
        output o_IBus_ReadData, o_IBus_WaitReq,
        input  i_DBus_Address, i_DBus_ByteEn, i_DBus_Read, i_DBus_Write, i_DBus_WriteData,
        output o_DBus_ReadData, o_DBus_WaitRequest,
        output o_SBus_Address, o_SBus_ByteEn, o_SBus_Read, o_SBus_Write, o_SBus_WriteData,
        input  i_SBus_ReadData, i_SBus_WaitReq,
        output o_Grant
    );

    // Environment view: CPU masters plus the system-bus slave.
    modport master (
        output i_IBus_Address, i_IBus_Read,
        input  o_IBus_ReadData, o_IBus_WaitReq,
        output i_DBus_Address, i_DBus_ByteEn, i_DBus_Read, i_DBus_Write, i_DBus_WriteData,
        input  o_DBus_ReadData, o_DBus_WaitRequest,
        input  o_SBus_Address, o_SBus_ByteEn, o_SBus_Read, o_SBus_Write, o_SBus_WriteData,
        output i_SBus_ReadData, i_SBus_WaitReq,
        input  o_Grant
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Two-master (IBus read-only, DBus read/write) to one system-bus arbiter.
// Registered arbitration with DBus priority; a streak counter forces an IBus
// grant after MAX_D_STREAK consecutive DBus wins while IBus waits.
//
// state  | meaning
// IDLE   | arbitration cycle, no bus activity, both masters stalled
// GNT_I  | IBus owns the system bus until its read completes or is dropped
// GNT_D  | DBus owns the system bus until its access completes or is dropped
module cpu_bus_arbiter #(
    parameter int ADDR_WIDTH   = 30,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    cpu_bus_arbiter_if.slave    bus
);

    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   streak_q;
    logic [1:0]      grant_q;

    logic req_i;
    logic req_d;
    logic force_i;

    assign req_i   = bus.i_IBus_Read;
    assign req_d   = bus.i_DBus_Read | bus.i_DBus_Write;
    // With the guard disabled the counter never leaves 0, so only gate on the parameter.
    assign force_i = (MAX_D_STREAK != 0) && (streak_q == STREAK_MAX);

    // Arbitration FSM, starvation counter and registered grant indication.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            grant_q  <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_d && !(req_i && force_i)) begin
                        state_q <= GNT_D;
                        grant_q <= 2'b10;
                        if (!req_i)
                            streak_q <= '0;
                        else if (streak_q != STREAK_MAX)
                            streak_q <= streak_q + SW'(1);
                    end else if (req_i) begin
                        state_q  <= GNT_I;
                        grant_q  <= 2'b01;
                        streak_q <= '0;
                    end
                end
                // Leave on completion, or at once if the master abandons its request.
                GNT_I: begin
                    if (!(req_i && bus.i_SBus_WaitReq)) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                GNT_D: begin
                    if (!(req_d && bus.i_SBus_WaitReq)) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign bus.o_Grant = grant_q;

    // Combinational pass-through of the granted master; everything quiet in IDLE.
    always_comb begin
        bus.o_SBus_Address     = '0;
        bus.o_SBus_ByteEn      = 4'h0;
        bus.o_SBus_Read        = 1'b0;
        bus.o_SBus_Write       = 1'b0;
        bus.o_SBus_WriteData   = 32'h0;
        bus.o_IBus_WaitReq     = 1'b1;
        bus.o_DBus_WaitRequest = 1'b1;
        bus.o_IBus_ReadData    = 32'h0;
        bus.o_DBus_ReadData    = 32'h0;
        unique case (state_q)
            GNT_I: begin
                bus.o_SBus_Address  = bus.i_IBus_Address;
                bus.o_SBus_ByteEn   = 4'hF;
                bus.o_SBus_Read     = 1'b1;
                bus.o_IBus_WaitReq  = bus.i_SBus_WaitReq;
                bus.o_IBus_ReadData = bus.i_SBus_ReadData;
            end
            GNT_D: begin
                bus.o_SBus_Address     = bus.i_DBus_Address;
                bus.o_SBus_ByteEn      = bus.i_DBus_ByteEn;
                bus.o_SBus_Read        = bus.i_DBus_Read;
                bus.o_SBus_Write       = bus.i_DBus_Write;
                bus.o_SBus_WriteData   = bus.i_DBus_WriteData;
                bus.o_DBus_WaitRequest = bus.i_SBus_WaitReq;
                bus.o_DBus_ReadData    = bus.i_SBus_ReadData;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: scoreboard of expected bus completions
// plus cycle-accurate checks on grant and wait-request timing.
`timescale 1ns/1ps
module tb_cpu_bus_arbiter;
    localparam int AW = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_arbiter_if #(.ADDR_WIDTH(AW)) bus0 ();
    cpu_bus_arbiter_if #(.ADDR_WIDTH(AW)) bus1 ();

    cpu_bus_arbiter #(.ADDR_WIDTH(AW), .MAX_D_STREAK(4)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus0.slave));
    cpu_bus_arbiter #(.ADDR_WIDTH(AW), .MAX_D_STREAK(0)) dut_nog (
        .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus1.slave));

    function automatic logic [31:0] rd_fn(input logic [AW-1:0] a);
        return {a, 2'b11} ^ 32'hC0DE_0000;
    endfunction

    // Slave model for dut: cfg_wait wait cycles per access, data from address.
    logic        sb_active;
    int unsigned cfg_wait = 0;
    int unsigned sl_cnt = 0;
    assign sb_active = bus0.o_SBus_Read | bus0.o_SBus_Write;
    always @(posedge clk) begin
        if (!sb_active) sl_cnt <= cfg_wait;
        else if (sl_cnt != 0) sl_cnt <= sl_cnt - 1;
    end
    assign bus0.i_SBus_WaitReq  = sb_active && (sl_cnt != 0);
    assign bus0.i_SBus_ReadData = rd_fn(bus0.o_SBus_Address);
    assign bus1.i_SBus_WaitReq  = 1'b0;
    assign bus1.i_SBus_ReadData = rd_fn(bus1.o_SBus_Address);

    typedef struct packed {
        logic [1:0]    grant;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic          rd;
        logic          wr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        logic [31:0]   other_rdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   i_leak = 0;
    int   d_leak = 0;
    int   idle_leak = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic txn_t mk_i(input logic [AW-1:0] a);
        txn_t t;
        t.grant = 2'b01; t.addr = a; t.be = 4'hF; t.rd = 1'b1; t.wr = 1'b0;
        t.wdata = 32'h0; t.rdata = rd_fn(a); t.other_rdata = 32'h0;
        return t;
    endfunction

    function automatic txn_t mk_d(input logic [AW-1:0] a, input logic [3:0] be,
                                  input logic rd, input logic wr, input logic [31:0] wd);
        txn_t t;
        t.grant = 2'b10; t.addr = a; t.be = be; t.rd = rd; t.wr = wr;
        t.wdata = wd; t.rdata = rd_fn(a); t.other_rdata = 32'h0;
        return t;
    endfunction

    // Monitor: every completion cycle on dut is popped against the scoreboard.
    always @(negedge clk) begin
        txn_t obs;
        txn_t e;
        if (rst_n && ((bus0.o_Grant == 2'b01 && !bus0.o_IBus_WaitReq) ||
                      (bus0.o_Grant == 2'b10 && !bus0.o_DBus_WaitRequest))) begin
            obs.grant = bus0.o_Grant;
            obs.addr  = bus0.o_SBus_Address;
            obs.be    = bus0.o_SBus_ByteEn;
            obs.rd    = bus0.o_SBus_Read;
            obs.wr    = bus0.o_SBus_Write;
            obs.wdata = bus0.o_SBus_WriteData;
            obs.rdata       = (bus0.o_Grant == 2'b01) ? bus0.o_IBus_ReadData : bus0.o_DBus_ReadData;
            obs.other_rdata = (bus0.o_Grant == 2'b01) ? bus0.o_DBus_ReadData : bus0.o_IBus_ReadData;
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL txn: unexpected completion got %h expected none", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs === e) n_pass++;
                else $display("FAIL txn: got %h expected %h", obs, e);
            end
        end
    end

    // Stall/idle invariants on dut, tallied over the whole run.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.o_Grant == 2'b10 && !bus0.o_IBus_WaitReq) i_leak++;
            if (bus0.o_Grant == 2'b01 && !bus0.o_DBus_WaitRequest) d_leak++;
            if (bus0.o_Grant == 2'b00 && (!bus0.o_IBus_WaitReq || !bus0.o_DBus_WaitRequest ||
                                          bus0.o_SBus_Read || bus0.o_SBus_Write)) idle_leak++;
        end
    end

    task automatic wait_cmpl(input bit is_d, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = is_d ? (bus0.o_Grant == 2'b10 && !bus0.o_DBus_WaitRequest)
                        : (bus0.o_Grant == 2'b01 && !bus0.o_IBus_WaitReq);
        end
        chk(name, seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_grant"}, bus0.o_Grant, 2'b00);
        chk({tag, "_sread"}, bus0.o_SBus_Read, 0);
        chk({tag, "_swrite"}, bus0.o_SBus_Write, 0);
        chk({tag, "_saddr"}, bus0.o_SBus_Address, 0);
        chk({tag, "_sbe"}, bus0.o_SBus_ByteEn, 0);
        chk({tag, "_swdata"}, bus0.o_SBus_WriteData, 0);
        chk({tag, "_iwait"}, bus0.o_IBus_WaitReq, 1);
        chk({tag, "_dwait"}, bus0.o_DBus_WaitRequest, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i_cnt;
        int d_cnt;
        bit got;
        bus0.i_IBus_Address = '0; bus0.i_IBus_Read = 0;
        bus0.i_DBus_Address = '0; bus0.i_DBus_ByteEn = 4'h0; bus0.i_DBus_Read = 0;
        bus0.i_DBus_Write = 0; bus0.i_DBus_WriteData = 32'h0;
        bus1.i_IBus_Address = '0; bus1.i_IBus_Read = 0;
        bus1.i_DBus_Address = '0; bus1.i_DBus_ByteEn = 4'h0; bus1.i_DBus_Read = 0;
        bus1.i_DBus_Write = 0; bus1.i_DBus_WriteData = 32'h0;

        #1;
        chk_reset_outs("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // IBus read, zero wait
        cfg_wait = 0;
        exp_q.push_back(mk_i(30'h100));
        bus0.i_IBus_Address = 30'h100; bus0.i_IBus_Read = 1;
        @(negedge clk);
        chk("t1_c1_grant", bus0.o_Grant, 2'b00);
        chk("t1_c1_iwait", bus0.o_IBus_WaitReq, 1);
        @(negedge clk);
        chk("t1_c2_grant", bus0.o_Grant, 2'b01);
        chk("t1_c2_sread", bus0.o_SBus_Read, 1);
        chk("t1_c2_sbe", bus0.o_SBus_ByteEn, 4'hF);
        chk("t1_c2_iwait", bus0.o_IBus_WaitReq, 0);
        chk("t1_c2_irdata", bus0.o_IBus_ReadData, rd_fn(30'h100));
        @(posedge clk); #1;
        bus0.i_IBus_Read = 0;
        @(negedge clk);
        chk("t1_c3_grant", bus0.o_Grant, 2'b00);

        // DBus write with 3 slave wait cycles
        @(posedge clk); #1;
        cfg_wait = 3;
        exp_q.push_back(mk_d(30'h20, 4'b0011, 0, 1, 32'h55AA_1234));
        bus0.i_DBus_Address = 30'h20; bus0.i_DBus_ByteEn = 4'b0011;
        bus0.i_DBus_WriteData = 32'h55AA_1234; bus0.i_DBus_Write = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_dwait", bus0.o_DBus_WaitRequest, (k < 4) ? 1 : 0);
            if (k > 0) begin
                chk("t2_swrite", bus0.o_SBus_Write, 1);
                chk("t2_sbe", bus0.o_SBus_ByteEn, 4'b0011);
                chk("t2_swdata", bus0.o_SBus_WriteData, 32'h55AA_1234);
                chk("t2_saddr", bus0.o_SBus_Address, 30'h20);
            end
        end
        @(posedge clk); #1;
        bus0.i_DBus_Write = 0; bus0.i_DBus_ByteEn = 4'h0; bus0.i_DBus_WriteData = 32'h0;

        // Simultaneous requests: DBus first, then IBus
        @(posedge clk); #1;
        cfg_wait = 1;
        exp_q.push_back(mk_d(30'h44, 4'hF, 1, 0, 32'h0));
        exp_q.push_back(mk_i(30'h300));
        bus0.i_DBus_Address = 30'h44; bus0.i_DBus_ByteEn = 4'hF; bus0.i_DBus_Read = 1;
        bus0.i_IBus_Address = 30'h300; bus0.i_IBus_Read = 1;
        @(negedge clk);
        chk("t3_idle", bus0.o_Grant, 2'b00);
        @(negedge clk);
        chk("t3_grant_d", bus0.o_Grant, 2'b10);
        chk("t3_iwait", bus0.o_IBus_WaitReq, 1);
        wait_cmpl(1, "t3_d_done");
        bus0.i_DBus_Read = 0;
        wait_cmpl(0, "t3_i_done");
        bus0.i_IBus_Read = 0;

        // Continuous DBus with IBus pending: 4 D grants then 1 I, twice
        cfg_wait = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(mk_d(30'h48, 4'hF, 1, 0, 32'h0));
            exp_q.push_back(mk_i(30'h304));
        end
        bus0.i_DBus_Address = 30'h48; bus0.i_DBus_Read = 1;
        bus0.i_IBus_Address = 30'h304; bus0.i_IBus_Read = 1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("t4_drain", exp_q.size(), 0);
        bus0.i_DBus_Read = 0; bus0.i_IBus_Read = 0;
        @(negedge clk);
        chk("t4_idle", bus0.o_Grant, 2'b00);

        // Guard disabled: IBus starves while DBus keeps requesting
        bus1.i_DBus_Address = 30'h50; bus1.i_DBus_ByteEn = 4'hF; bus1.i_DBus_Read = 1;
        bus1.i_IBus_Address = 30'h308; bus1.i_IBus_Read = 1;
        i_cnt = 0; d_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus1.o_Grant == 2'b01) i_cnt++;
            if (bus1.o_Grant == 2'b10 && !bus1.o_DBus_WaitRequest) d_cnt++;
        end
        chk("t5_no_ibus", i_cnt, 0);
        chk("t5_d_served", (d_cnt >= 15) ? 1 : 0, 1);
        @(posedge clk); #1;
        bus1.i_DBus_Read = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = (bus1.o_Grant == 2'b01);
        end
        chk("t5_ibus_after", got, 1);
        @(posedge clk); #1;
        bus1.i_IBus_Read = 0;

        // Reset during a DBus slave wait, then re-arbitration
        @(posedge clk); #1;
        cfg_wait = 5;
        bus0.i_DBus_Address = 30'h60; bus0.i_DBus_ByteEn = 4'hF; bus0.i_DBus_Read = 1;
        @(negedge clk);
        chk("t6_idle0", bus0.o_Grant, 2'b00);
        @(negedge clk);
        chk("t6_grant_d", bus0.o_Grant, 2'b10);
        chk("t6_dwait", bus0.o_DBus_WaitRequest, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs("t6_rst");
        cfg_wait = 1;
        exp_q.push_back(mk_d(30'h60, 4'hF, 1, 0, 32'h0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rearb_idle", bus0.o_Grant, 2'b00);
        @(negedge clk);
        chk("t6_rearb_d", bus0.o_Grant, 2'b10);
        wait_cmpl(1, "t6_d_done");
        bus0.i_DBus_Read = 0;
        repeat (2) @(negedge clk);

        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_ibus_leak", i_leak, 0);
        chk("end_dbus_leak", d_leak, 0);
        chk("end_idle_leak", idle_leak, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
Two-master to one-slave arbiter sitting directly downstream of the CPU core. It merges the CPU instruction bus (read-only) and data bus (read/write) onto a single system bus. Arbitration is registered: DBus has fixed priority, with a starvation guard that protects instruction fetch. The granted master's transaction passes through combinationally; the non-granted master is held with wait-request.

Parameters:
ADDR_WIDTH, 30, word-address width on all three buses.
MAX_D_STREAK, 4, consecutive DBus grants allowed while IBus is pending before IBus is forced; 0 disables the guard (strict DBus priority).

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_IBus_Address  in  ADDR_WIDTH  instruction word address
i_IBus_Read  in  1  instruction read request
o_IBus_ReadData  out  32  instruction read data
o_IBus_WaitReq  out  1  stall to IBus master
i_DBus_Address  in  ADDR_WIDTH  data word address
i_DBus_ByteEn  in  4  data byte enables
i_DBus_Read  in  1  data read request
i_DBus_Write  in  1  data write request
i_DBus_WriteData  in  32  data write data
o_DBus_ReadData  out  32  data read data
o_DBus_WaitRequest  out  1  stall to DBus master
o_SBus_Address  out  ADDR_WIDTH  system bus address
o_SBus_ByteEn  out  4  system bus byte enables
o_SBus_Read  out  1  system bus read
o_SBus_Write  out  1  system bus write
o_SBus_WriteData  out  32  system bus write data
i_SBus_ReadData  in  32  system bus read data
i_SBus_WaitReq  in  1  system bus wait-request
o_Grant  out  2  current grant: 00 none, 01 IBus, 10 DBus

Behaviour:
- Reset (async, i_Rst_n=0): state=IDLE, streak counter=0.
  - While in reset: o_SBus_Read/Write=0, o_SBus_Address/ByteEn/WriteData=0, o_Grant=00, o_IBus_WaitReq=1, o_DBus_WaitRequest=1.
  - Reset mid-transaction abandons the transaction; no completion is signalled to either master.
- State machine: IDLE, GNT_I, GNT_D.
  - Requests: reqI=i_IBus_Read; reqD=i_DBus_Read|i_DBus_Write.
  - IDLE, no request: stay in IDLE.
  - IDLE, reqD only: go to GNT_D.
  - IDLE, reqI only: go to GNT_I.
  - IDLE, both requesting: go to GNT_D, unless MAX_D_STREAK!=0 and streak==MAX_D_STREAK, in which case go to GNT_I.
  - GNT_x: stay until the completion cycle (granted request high and i_SBus_WaitReq=0), then go to IDLE.
  - Every transaction therefore costs at least one IDLE arbitration cycle plus one bus cycle.
- Streak counter:
  - On an IDLE->GNT_D transition with reqI=1: increment, saturating at MAX_D_STREAK.
  - On any IDLE->GNT_I transition: clear to 0.
  - On an IDLE->GNT_D transition with reqI=0: clear to 0.
- Datapath in GNT_I:
  - SBus address = IBus address; ByteEn=4'hF; Read=1; Write=0; WriteData=0.
  - o_IBus_WaitReq=i_SBus_WaitReq; o_DBus_WaitRequest=1.
- Datapath in GNT_D:
  - DBus address, ByteEn, Read, Write and WriteData are passed straight to SBus.
  - o_DBus_WaitRequest=i_SBus_WaitReq; o_IBus_WaitReq=1.
- Datapath in IDLE: SBus Read/Write=0; both wait-requests=1.
- Read data: i_SBus_ReadData is routed to the granted master's ReadData; the other master's ReadData=0. Data is valid in the completion cycle only.
- Protocol rules:
  - Masters hold address, data and request stable until their wait-request is low.
  - A request dropped while granted and not yet complete returns the FSM to IDLE on the next cycle, with no counter update.
  - DBus Read and Write both high is illegal; it is forwarded unchanged.
- Completion cycle: the other master's request is not observed; it is arbitrated in the following IDLE cycle.

Test Plan:
- Reset, then IBus read of 0x100 with slave waitreq=0 → cycle 1: Grant=00; cycle 2: Grant=01, SBus_Read=1, ByteEn=F, IBus_WaitReq=0, IBus_ReadData=slave data; cycle 3: IDLE.
- DBus write of 0x55AA_1234 to addr 0x20 with ByteEn=0011 and 3 slave wait cycles → DBus_WaitRequest high for 1 IDLE cycle plus 3 wait cycles, low in the 5th cycle; SBus_Write/ByteEn/data match throughout.
- IBus and DBus request in the same cycle, streak=0 → DBus served first; IBus served in the next grant; IBus_WaitReq=1 throughout the DBus grant.
- DBus requests back-to-back continuously with IBus pending, MAX_D_STREAK=4 → exactly 4 DBus grants, then 1 IBus grant, then the streak counter reads 0.
- MAX_D_STREAK=0, same stimulus as the previous scenario → IBus is never granted while DBus keeps requesting.
- Assert i_Rst_n low mid-GNT_D during a slave wait → all outputs go to their reset values immediately (asynchronously); after release, the still-pending DBus request is re-arbitrated via IDLE.
